// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell, reused serially by serial_add_ctrl.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: one full-adder cell walks the operands LSB first.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input selecting op_a - op_b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Subtraction is two's complement: invert B and force the initial carry.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~op_b : op_b;
    assign c_load = sub ? 1'b1  : cin;
`else
    assign b_load = op_b;
    assign c_load = cin;
`endif

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry  <= fa_co;
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // The final bit lands straight in sum so it is valid alongside done.
                    if (cnt == LAST) begin
                        sum   <= {fa_s, res_sh[WIDTH-1:1]};
                        cout  <= fa_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
    localparam int LIMIT = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int tests    = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Ticks until done is seen or the cycle budget runs out; n = edges waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < LIMIT);
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int n;
        apply_stimulus(a, b, c);
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check_output({tag, "_latency"}, 32'(n), 32'(WIDTH));
        check_output({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check_output({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_output({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [WIDTH:0] ref_val;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) tick();
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_sum",  32'(sum),  32'd0);
        check_output("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // A second start during RUN must not disturb the first result.
        apply_stimulus(8'h5A, 8'h33, 1'b0);
        repeat (3) tick();
        op_a  = 8'h11;
        op_b  = 8'h22;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check_output("ignore_latency", 32'(n + 4), 32'(WIDTH));
        check_output("ignore_sum", 32'(sum), 32'h8D);
        check_output("ignore_cout", 32'(cout), 32'd0);
        pulses = 0;
        repeat (2 * WIDTH) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check_output("ignore_single_done", 32'(pulses), 32'd0);
        check_output("ignore_idle", 32'(busy), 32'd0);

        // Abort mid-operation after four bits have been processed.
        apply_stimulus(8'hC3, 8'h3C, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_sum",  32'(sum),  32'd0);
        check_output("abort_cout", 32'(cout), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        pulses = 0;
        repeat (2 * WIDTH) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check_output("abort_no_done", 32'(pulses), 32'd0);
        run_op("after_abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // Start held high: each accept follows the previous done by two edges.
        op_a  = 8'h01;
        op_b  = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        wait_done(n);
        check_output("b2b0_latency", 32'(n), 32'(WIDTH));
        check_output("b2b0_sum", 32'(sum), 32'h03);
        check_output("b2b0_cout", 32'(cout), 32'd0);
        op_a = 8'h80;
        op_b = 8'h80;
        cin  = 1'b0;
        wait_done(n);
        check_output("b2b1_period", 32'(n), 32'(WIDTH + 2));
        check_output("b2b1_sum", 32'(sum), 32'h00);
        check_output("b2b1_cout", 32'(cout), 32'd1);
        op_a = 8'h7F;
        op_b = 8'h01;
        cin  = 1'b1;
        wait_done(n);
        check_output("b2b2_period", 32'(n), 32'(WIDTH + 2));
        check_output("b2b2_sum", 32'(sum), 32'h81);
        check_output("b2b2_cout", 32'(cout), 32'd0);
        start = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            ref_val = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            run_op($sformatf("rand%0d", i), ra, rb, rc, ref_val[WIDTH-1:0], ref_val[WIDTH]);
        end

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
        sub = 1'b0;
        run_op("nosub_10_01", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
